// File: rtl/spi_xfer_ctrl_if.sv
// Register-block side of the SPI transfer sequencer: transfer request/data in,
// progress, receive strobe and received byte out.
interface spi_xfer_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              send_data;
    logic [DATA_W-1:0] mosi_data;
    logic              tip;
    logic              receive_data;
    logic [DATA_W-1:0] miso_data;

    modport master (output send_data, mosi_data, input tip, receive_data, miso_data);
    modport slave  (input send_data, mosi_data, output tip, receive_data, miso_data);
endinterface

// File: rtl/spi_xfer_ctrl.sv
// Master-mode SPI transfer sequencer: baud divider, edge sequencing and the
// transmit/receive shift registers between the register block and the SPI pins.
module spi_xfer_ctrl #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 12
) (
    input  logic           pclk,
    input  logic           preset_n,
    input  logic           mstr,
    input  logic           cpol,
    input  logic           cpha,
    input  logic           lsbfe,
    input  logic           spiswai,
    input  logic [2:0]     sppr,
    input  logic [2:0]     spr,
    input  logic [1:0]     spi_mode,
    input  logic           miso,
    output logic           sclk,
    output logic           mosi,
    output logic           ss,
    spi_xfer_ctrl_if.slave xfer
);
    localparam int EDGES  = 2 * DATA_W;
    localparam int EDGE_W = $clog2(EDGES + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TRAIL, DONE} state_t;

    state_t              state, next_state;
    logic [DIV_W-1:0]    div_cnt, half_q, half_d;
    logic [EDGE_W-1:0]   edge_cnt;
    logic [DATA_W-1:0]   tx_sr, rx_sr, miso_q;
    logic                cpol_q, cpha_q, lsbfe_q;
    logic                act, start, phase_end, last_edge, edge_tick;

    function automatic logic pick(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        act        = mstr && (spi_mode == 2'b00 || (spi_mode == 2'b01 && !spiswai));
        start      = (state == IDLE) && xfer.send_data && act;
        half_d     = (DIV_W'(sppr) + DIV_W'(1)) << spr;
        phase_end  = (div_cnt == half_q - DIV_W'(1));
        last_edge  = (edge_cnt == EDGE_W'(EDGES - 1));
        edge_tick  = (state == SHIFT) && act && phase_end;
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = SETUP;
            SETUP: if (!mstr) next_state = IDLE;
                   else if (act && phase_end) next_state = SHIFT;
            SHIFT: if (!mstr) next_state = IDLE;
                   else if (edge_tick && last_edge) next_state = TRAIL;
            TRAIL: if (!mstr) next_state = IDLE;
                   else if (act && phase_end) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state elements use non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge pclk) begin
        if (!preset_n) state <= IDLE;
        else           state <= next_state;
    end

    assign xfer.tip          = (state != IDLE);
    assign ss                = (state == IDLE) || (state == DONE);
    assign xfer.receive_data = (state == DONE);
    assign xfer.miso_data    = miso_q;

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            sclk     <= cpol;
            mosi     <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            miso_q   <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            half_q   <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsbfe_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sclk    <= cpol;
                    div_cnt <= '0;
                    if (start) begin
                        half_q   <= half_d;
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        lsbfe_q  <= lsbfe;
                        edge_cnt <= '0;
                        // With cpha=0 the first bit must be on mosi before the leading edge.
                        if (!cpha) begin
                            mosi  <= pick(xfer.mosi_data, lsbfe);
                            tx_sr <= advance(xfer.mosi_data, lsbfe);
                        end else begin
                            tx_sr <= xfer.mosi_data;
                        end
                    end
                end
                DONE: sclk <= cpol_q;
                default: begin
                    if (!mstr) begin
                        sclk <= cpol;
                    end else if (act) begin
                        div_cnt <= phase_end ? '0 : div_cnt + DIV_W'(1);
                        if (edge_tick) begin
                            sclk     <= ~sclk;
                            edge_cnt <= edge_cnt + EDGE_W'(1);
                            // Edge parity vs cpha selects sample edges; the others drive the next bit.
                            if (edge_cnt[0] == cpha_q) begin
                                rx_sr <= lsbfe_q ? {miso, rx_sr[DATA_W-1:1]}
                                                 : {rx_sr[DATA_W-2:0], miso};
                            end else if (!last_edge) begin
                                mosi  <= pick(tx_sr, lsbfe_q);
                                tx_sr <= advance(tx_sr, lsbfe_q);
                            end
                        end
                        if (state == TRAIL && phase_end) miso_q <= rx_sr;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: directed scenarios plus randomized
// transfers scored against a bit-order/timing model of an SPI master.
module tb_spi_xfer_ctrl;
    logic       pclk = 1'b0;
    logic       preset_n = 1'b0;
    logic       mstr = 1'b1, cpol = 1'b0, cpha = 1'b0, lsbfe = 1'b0, spiswai = 1'b1;
    logic [2:0] sppr = 3'd0, spr = 3'd0;
    logic [1:0] spi_mode = 2'b00;
    logic       miso_drv = 1'b0, loopback = 1'b0;
    logic       sclk, mosi, ss;
    wire        miso_w;
    int         errors = 0, checks = 0;
    logic [7:0] exp_miso_data = 8'h00;

    spi_xfer_ctrl_if #(.DATA_W(8)) xfer ();

    assign miso_w = loopback ? mosi : miso_drv;

    spi_xfer_ctrl #(.DATA_W(8), .DIV_W(12)) dut (
        .pclk(pclk), .preset_n(preset_n), .mstr(mstr), .cpol(cpol), .cpha(cpha),
        .lsbfe(lsbfe), .spiswai(spiswai), .sppr(sppr), .spr(spr), .spi_mode(spi_mode),
        .miso(miso_w), .sclk(sclk), .mosi(mosi), .ss(ss), .xfer(xfer)
    );

    always #5 pclk = ~pclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // One full transfer: model gives bit order, received byte and edge/strobe timing.
    task automatic do_xfer(input string name, input logic [7:0] data, input logic [7:0] slave_byte,
                           input logic c_pol, input logic c_pha, input logic lsb,
                           input logic [2:0] pp, input logic [2:0] rr, input bit loop,
                           input int frz_edge, input int frz_len, input bit frz_wait,
                           input bit scramble);
        int h, budget, edges, n_smp, rx_cnt, rx_obs, low_obs, frz_left, timing_bad;
        logic [7:0] exp_seq, slave_seq, exp_rx, got_seq, got_rx;
        logic prev_sclk, frz_sclk, frz_mosi, frz_bad, idle_sclk, idle_ss;
        h = (int'(pp) + 1) << rr;
        for (int i = 0; i < 8; i++) begin
            exp_seq[i]   = lsb ? data[i] : data[7-i];
            slave_seq[i] = lsb ? slave_byte[i] : slave_byte[7-i];
        end
        exp_rx = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (lsb) exp_rx[i]   = loop ? exp_seq[i] : slave_seq[i];
            else     exp_rx[7-i] = loop ? exp_seq[i] : slave_seq[i];
        end
        edges = 0; n_smp = 0; rx_cnt = 0; rx_obs = 0; low_obs = 0; frz_left = 0; timing_bad = 0;
        got_seq = 8'h00; got_rx = 8'h00; frz_bad = 1'b0; frz_sclk = 1'b0; frz_mosi = 1'b0;
        idle_sclk = 1'bx; idle_ss = 1'bx;

        @(negedge pclk);
        cpol = c_pol; cpha = c_pha; lsbfe = lsb; sppr = pp; spr = rr;
        mstr = 1'b1; spi_mode = 2'b00; spiswai = 1'b1;
        loopback = loop; miso_drv = slave_seq[0]; xfer.mosi_data = data;
        @(negedge pclk);
        xfer.send_data = 1'b1;
        prev_sclk = c_pol;
        budget = 18 * h + frz_len + 8;
        for (int obs = 1; obs <= budget; obs++) begin
            @(negedge pclk);
            if (obs == 1) begin
                xfer.send_data = 1'b0;
                checks++;
                if (ss !== 1'b0 || xfer.tip !== 1'b1) begin
                    errors++;
                    $display("FAIL %s start: ss=%b tip=%b, need ss=0 tip=1", name, ss, xfer.tip);
                end
                if (scramble) begin
                    cpol = 1'($urandom); cpha = 1'($urandom); lsbfe = 1'($urandom);
                    sppr = 3'($urandom); spr = 3'($urandom); xfer.mosi_data = 8'($urandom);
                end
            end
            if (frz_left > 0) begin
                if (sclk !== frz_sclk || mosi !== frz_mosi || ss !== 1'b0 || xfer.tip !== 1'b1)
                    frz_bad = 1'b1;
                frz_left--;
                if (frz_left == 0) spi_mode = 2'b00;
            end
            if (sclk !== prev_sclk) begin
                edges++;
                prev_sclk = sclk;
                if (edges > 16 || obs != (edges + 1) * h + 1 + ((edges > frz_edge) ? frz_len : 0))
                    timing_bad++;
                if (((edges % 2) == 1) == (c_pha == 1'b0) && n_smp < 8) begin
                    got_seq[n_smp] = mosi;
                    n_smp++;
                    if (n_smp < 8) miso_drv = slave_seq[n_smp];
                end
                if (frz_len > 0 && edges == frz_edge) begin
                    spi_mode = frz_wait ? 2'b01 : 2'b10;
                    frz_left = frz_len; frz_sclk = sclk; frz_mosi = mosi;
                end
                if (scramble && edges == 16) begin
                    cpol = c_pol; cpha = c_pha; lsbfe = lsb; sppr = pp; spr = rr;
                end
            end
            if (xfer.receive_data === 1'b1) begin
                rx_cnt++; rx_obs = obs; got_rx = xfer.miso_data;
            end
            if (xfer.tip === 1'b0) begin
                low_obs = obs; idle_sclk = sclk; idle_ss = ss;
                break;
            end
        end
        if (scramble) begin
            cpol = c_pol; cpha = c_pha; lsbfe = lsb; sppr = pp; spr = rr;
        end
        spi_mode = 2'b00;

        checks++;
        if (edges != 16) begin
            errors++; $display("FAIL %s edge_count: got %0d, need 16", name, edges);
        end
        checks++;
        if (timing_bad != 0) begin
            errors++; $display("FAIL %s edge_timing: %0d misplaced edges, need 0 (H=%0d)", name, timing_bad, h);
        end
        checks++;
        if (n_smp != 8 || got_seq !== exp_seq) begin
            errors++; $display("FAIL %s mosi_order: got %b (%0d bits), need %b", name, got_seq, n_smp, exp_seq);
        end
        checks++;
        if (rx_cnt != 1 || rx_obs != 18 * h + 1 + frz_len) begin
            errors++; $display("FAIL %s rx_pulse: %0d pulses at cycle %0d, need 1 at %0d", name, rx_cnt, rx_obs, 18 * h + 1 + frz_len);
        end
        checks++;
        if (got_rx !== exp_rx) begin
            errors++; $display("FAIL %s miso_data: got %h, need %h", name, got_rx, exp_rx);
        end
        checks++;
        if (low_obs != 18 * h + 2 + frz_len) begin
            errors++; $display("FAIL %s tip_length: tip fell at cycle %0d, need %0d", name, low_obs, 18 * h + 2 + frz_len);
        end
        checks++;
        if (idle_sclk !== c_pol || idle_ss !== 1'b1) begin
            errors++; $display("FAIL %s idle: sclk=%b ss=%b, need sclk=%b ss=1", name, idle_sclk, idle_ss, c_pol);
        end
        if (frz_len > 0) begin
            checks++;
            if (frz_bad) begin
                errors++; $display("FAIL %s freeze: outputs moved while frozen, need hold", name);
            end
        end
        exp_miso_data = exp_rx;
    endtask

    task automatic test_reset();
        @(negedge pclk);
        preset_n = 1'b0; cpol = 1'b1; xfer.send_data = 1'b0; xfer.mosi_data = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            checks++;
            if (sclk !== 1'b1 || ss !== 1'b1 || xfer.tip !== 1'b0 || xfer.receive_data !== 1'b0 ||
                xfer.miso_data !== 8'h00) begin
                errors++;
                $display("FAIL reset[%0d]: sclk=%b ss=%b tip=%b rx=%b data=%h, need 1 1 0 0 00",
                         i, sclk, ss, xfer.tip, xfer.receive_data, xfer.miso_data);
            end
        end
        preset_n = 1'b1;
        exp_miso_data = 8'h00;
    endtask

    task automatic test_mode0();
        do_xfer("mode0", 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_lsb_cpha1();
        do_xfer("lsb_cpha1", 8'h3C, 8'hC3, 1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_baud();
        do_xfer("baud_h6", 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 3'd2, 3'd1, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_freeze();
        do_xfer("freeze", 8'h96, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 5, 20, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        int edges;
        logic prev;
        bit hit, bad;
        @(negedge pclk);
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sppr = 3'd1; spr = 3'd0;
        mstr = 1'b1; spi_mode = 2'b00; loopback = 1'b1; xfer.mosi_data = 8'h5A;
        @(negedge pclk);
        xfer.send_data = 1'b1;
        prev = cpol; edges = 0; hit = 1'b0; bad = 1'b0;
        for (int obs = 1; obs <= 60; obs++) begin
            @(negedge pclk);
            if (obs == 1) xfer.send_data = 1'b0;
            if (sclk !== prev) begin edges++; prev = sclk; end
            if (edges == 7) begin mstr = 1'b0; hit = 1'b1; break; end
        end
        @(negedge pclk);
        checks++;
        if (!hit || ss !== 1'b1 || xfer.tip !== 1'b0 || sclk !== 1'b0 || xfer.receive_data !== 1'b0) begin
            errors++;
            $display("FAIL abort: reached=%0d ss=%b tip=%b sclk=%b rx=%b, need 1 1 0 0 0",
                     hit, ss, xfer.tip, sclk, xfer.receive_data);
        end
        xfer.send_data = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (xfer.tip !== 1'b0 || xfer.receive_data !== 1'b0 || xfer.miso_data !== exp_miso_data) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_hold: tip=%b rx=%b data=%h, need 0 0 %h", xfer.tip, xfer.receive_data,
                     xfer.miso_data, exp_miso_data);
        end
        xfer.send_data = 1'b0; mstr = 1'b1;
    endtask

    task automatic test_reset_mid();
        @(negedge pclk);
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sppr = 3'd0; spr = 3'd0;
        loopback = 1'b1; xfer.mosi_data = 8'hFF;
        xfer.send_data = 1'b1;
        @(negedge pclk);
        xfer.send_data = 1'b0;
        repeat (6) @(negedge pclk);
        preset_n = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
        checks++;
        if (ss !== 1'b1 || xfer.tip !== 1'b0 || sclk !== 1'b0 || xfer.receive_data !== 1'b0 ||
            xfer.miso_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: ss=%b tip=%b sclk=%b rx=%b data=%h, need 1 0 0 0 00",
                     ss, xfer.tip, sclk, xfer.receive_data, xfer.miso_data);
        end
        exp_miso_data = 8'h00;
    endtask

    task automatic test_back_to_back();
        int rx_n, first_rx, second_rx, gap, low_run, second_start;
        logic [7:0] got0, got1;
        rx_n = 0; first_rx = 0; second_rx = 0; gap = -1; low_run = 0; second_start = 0;
        got0 = 8'h00; got1 = 8'h00;
        @(negedge pclk);
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sppr = 3'd0; spr = 3'd0;
        mstr = 1'b1; spi_mode = 2'b00; loopback = 1'b1; xfer.mosi_data = 8'h11;
        xfer.send_data = 1'b1;
        for (int obs = 1; obs <= 100; obs++) begin
            @(negedge pclk);
            if (obs == 1) xfer.mosi_data = 8'h22;
            if (xfer.receive_data === 1'b1) begin
                rx_n++;
                if (rx_n == 1) begin got0 = xfer.miso_data; first_rx = obs; end
                else if (rx_n == 2) begin got1 = xfer.miso_data; second_rx = obs; end
            end
            if (rx_n == 1 && xfer.tip === 1'b0) low_run++;
            if (rx_n == 1 && xfer.tip === 1'b1 && low_run > 0 && second_start == 0) begin
                gap = low_run; second_start = obs;
                xfer.send_data = 1'b0;
            end
            // Busy-period request pulses must be ignored.
            if (second_start > 0 && obs < second_start + 10) xfer.send_data = (obs % 2 == 0);
            else if (second_start > 0) xfer.send_data = 1'b0;
        end
        xfer.send_data = 1'b0;
        checks++;
        if (rx_n != 2) begin errors++; $display("FAIL b2b_count: got %0d transfers, need 2", rx_n); end
        checks++;
        if (got0 !== 8'h11 || got1 !== 8'h22) begin
            errors++; $display("FAIL b2b_data: got %h %h, need 11 22", got0, got1);
        end
        checks++;
        if (gap != 1) begin errors++; $display("FAIL b2b_gap: %0d idle cycles, need 1", gap); end
        checks++;
        if (second_rx - first_rx != 20) begin
            errors++; $display("FAIL b2b_spacing: %0d cycles between strobes, need 20", second_rx - first_rx);
        end
        exp_miso_data = 8'h22;
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            do_xfer($sformatf("rand%0d", t), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 2)), 1'($urandom),
                    int'($urandom_range(1, 15)), int'($urandom_range(0, 6)), 1'($urandom), 1'b1);
        end
    endtask

    initial begin
        xfer.send_data = 1'b0;
        xfer.mosi_data = 8'h00;
        test_reset();
        test_mode0();
        test_lsb_cpha1();
        test_baud();
        test_freeze();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
- Master-mode SPI transfer sequencer that sits between the APB register block and the SPI pins.
- Consumes the configuration outputs (mstr, cpol, cpha, lsbfe, spiswai, sppr, spr, spi_mode) and the send_data/mosi_data request.
- Generates sclk, mosi and ss, shifts in miso, and returns tip, receive_data and miso_data to the register block.
- Owns the baud divider and the 8-bit shift state machine.

Parameters:
- DATA_W, 8, shift register width; the edge count is 2*DATA_W.
- DIV_W, 12, width of the half-period counter; must hold (sppr+1)*2^spr, max 1024.

Ports:
- pclk  in  1  system clock
- preset_n  in  1  synchronous active-low reset
- mstr  in  1  master enable; 0 aborts or blocks transfers
- cpol  in  1  sclk idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- lsbfe  in  1  1: LSB first
- spiswai  in  1  1: stop shifting while in wait mode
- sppr  in  3  baud prescale
- spr  in  3  baud exponent
- spi_mode  in  2  00 run, 01 wait, 10 stop
- send_data  in  1  transfer request, level-sampled in IDLE only
- mosi_data  in  DATA_W  byte to transmit
- miso  in  1  serial input
- sclk  out  1  serial clock
- mosi  out  1  serial output
- ss  out  1  slave select, active low
- tip  out  1  transfer in progress
- receive_data  out  1  one-cycle pulse: miso_data valid
- miso_data  out  DATA_W  received byte

Behaviour:
- Clock and reset: one clock, pclk; reset preset_n is synchronous and active-low.
- Reset values: state=IDLE, sclk=cpol, ss=1, mosi=0, tip=0, receive_data=0, miso_data=0, counters=0.
  - Reset asserted mid-transfer returns to these values on the next edge; no receive_data pulse.
- Half period: H = (sppr+1) << spr, in pclk cycles. Minimum H=1, giving sclk=pclk/2. H is sampled when leaving IDLE and held for the whole transfer.
- Active condition: act = mstr && (spi_mode==00 || (spi_mode==01 && !spiswai)).
- States:
  - IDLE: sclk=cpol, ss=1, tip=0.
    - If send_data && act at cycle N: load shift reg <= mosi_data, clear edge counter, go to SETUP.
    - At N+1: ss=0, tip=1.
    - cpha=0: mosi = first bit (bit7, or bit0 if lsbfe) from N+1.
  - SETUP: hold for H cycles, then go to SHIFT.
  - SHIFT: sclk toggles every H cycles, 16 toggles total (edges 1..16). Odd edges are leading, even edges trailing.
    - cpha=0: sample miso on odd edges; drive next bit on even edges 2..14.
    - cpha=1: drive bit on odd edges; sample on even edges.
    - Sampling and driving occur in the pclk cycle where the sclk register updates.
    - Received bits fill from the MSB end (lsbfe=0) or the LSB end (lsbfe=1).
    - After edge 16, sclk=cpol; go to TRAIL.
  - TRAIL: hold for H cycles, then go to DONE.
  - DONE (1 cycle): ss=1, receive_data=1, miso_data=received byte, tip=1. Next cycle: IDLE, tip=0.
- Total tip-high time = 18H+1 cycles.
- send_data while not in IDLE: ignored, with no queuing. send_data still high on returning to IDLE starts a new transfer (back-to-back gap: one IDLE cycle).
- Freeze: if !act && mstr during SETUP/SHIFT/TRAIL (stop mode, or wait with spiswai):
  - counters, sclk, mosi and ss hold; tip stays 1;
  - resume exactly where frozen when act returns.
- Abort: mstr=0 in any non-IDLE state goes to IDLE next cycle. ss=1, sclk=cpol, tip=0, no receive_data; miso_data unchanged.
- Mid-transfer changes: cpol, cpha, lsbfe, sppr and spr changes during a transfer are ignored. They are latched at the IDLE exit.

Test Plan:
- Reset with cpol=1 -> sclk=1, ss=1, tip=0, receive_data=0, miso_data=00; hold 5 cycles, outputs unchanged.
- Mode 0, msb first, sppr=0, spr=0, mosi_data=A5, miso looped to mosi, send_data pulse at cycle N:
  - ss low at N+1;
  - mosi bit sequence 1,0,1,0,0,1,0,1;
  - 8 rising sclk edges;
  - receive_data pulses at N+19 with miso_data=A5;
  - tip low at N+20.
- cpol=1, cpha=1, lsbfe=1, mosi_data=3C, miso tied to a pattern that delivers C3 LSB-first -> mosi carries LSB first (0,0,1,1,1,1,0,0), sclk idles high, miso_data=C3.
- sppr=2, spr=1 (H=6) -> sclk half period exactly 6 pclk; tip high for 109 cycles.
- Freeze and abort:
  - spi_mode=10 asserted after edge 5 for 20 cycles -> sclk/mosi frozen, tip=1; completes afterwards with the correct byte.
  - Separately, mstr=0 after edge 7 -> next cycle ss=1, tip=0, sclk=cpol, no receive_data.
- send_data held high for 2 transfers with mosi_data=11 then 22 -> two back-to-back transfers, one IDLE cycle between them; second-cycle send_data pulses during the busy period are ignored.
